uart_tx_frame_arbiter: RTL
==========================

Name: uart_tx_frame_arbiter

Overview:
Shares the single uart_tx byte transmitter between NUM_REQ frame sources, for example the periodic sensor-report sender and an LED-command acknowledge sender. Arbitration is round-robin and frame-atomic: once a requester is granted, all of its bytes up to and including the one flagged last go out before any other requester is served. The block sequences the tx_start/tx_busy handshake of uart_tx and supervises it with a busy-rise watchdog. It sits between the string formatters and uart_tx.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
MAX_FRAME, 16, maximum bytes per frame; a frame is force-terminated at this count
BUSY_TIMEOUT, 16, cycles to wait for tx_busy to rise after tx_start before declaring a timeout

Ports:
clk_100Mhz  in  1  system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NUM_REQ  per-requester byte valid
req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i]
req_last  in  NUM_REQ  marks the final byte of a frame; qualified by req_valid
req_ready  out  NUM_REQ  byte accepted; one-hot or zero
tx_start  out  1  one-cycle start pulse to uart_tx
tx_data  out  8  byte to uart_tx; stable from the start pulse until the next byte is loaded
tx_busy  in  1  busy flag from uart_tx
grant_id  out  $clog2(NUM_REQ) (min 1)  index of the current or last granted requester
frame_active  out  1  high while a frame is owned
frame_done  out  1  one-cycle pulse when a frame finishes
err_timeout  out  1  sticky; tx_busy failed to rise within BUSY_TIMEOUT
err_trunc  out  1  sticky; a frame hit MAX_FRAME without req_last

Behaviour:
- Reset (rst_n low at a clock edge) takes priority over everything, including mid-frame. It forces state=IDLE, rr_ptr=0, and every output to 0 (tx_start, tx_data, req_ready, grant_id, frame_active, frame_done, err_timeout, err_trunc) plus all counters to 0. A byte in flight inside uart_tx is abandoned; that module resets itself from the same rst_n.
- The only way to clear the sticky error flags is reset.
- IDLE: if any req_valid is high, pick the first valid requester searching from rr_ptr upward with wrap. Register grant_id=g, set frame_active=1, clear byte_cnt, go to FETCH. With no valid requester, stay in IDLE.
- FETCH: req_ready[g] = req_valid[g] && !tx_busy, combinational from the registered state. All other ready bits stay 0.
  - On handshake: latch tx_data=req_data[g], latch last_q = req_last[g] or (byte_cnt==MAX_FRAME-1), set trunc_q = that last condition && !req_last[g], increment byte_cnt, go to START.
  - If req_valid[g] drops, stay in FETCH indefinitely. The frame is never preempted.
- START: tx_start=1 for exactly this cycle. Clear wd_cnt, go to WAIT_HI.
- WAIT_HI:
  - tx_busy=1: go to WAIT_LO.
  - Otherwise increment wd_cnt. When wd_cnt==BUSY_TIMEOUT-1, set err_timeout and treat the byte as sent (apply the WAIT_LO exit rule in the same cycle).
- WAIT_LO: when tx_busy=0, go to DONE if last_q is set, else go to FETCH.
- DONE (one cycle): frame_done=1, frame_active=0, err_trunc |= trunc_q, rr_ptr = (g+1) mod NUM_REQ, go to IDLE. grant_id holds its value.
- Timing:
  - A new frame can be granted in the cycle after DONE.
  - Minimum handshake-to-tx_start latency is 1 cycle.
  - Minimum inter-byte gap is FETCH→START→WAIT_HI plus uart_tx busy time.
- Simultaneous requests: served strictly round-robin. A requester that re-raises valid right after its own frame waits behind any other pending requester.
- req_last on a byte that is not granted is ignored.
- Byte count is 5 bits wide for the default parameters and $clog2(MAX_FRAME+1) in general; it never wraps, because the frame terminates at MAX_FRAME.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, FETCH, START, WAIT_HI, WAIT_LO, DONE)
  - ASCII constants used by the formatters: 'S', 'L', ':', '0', '\n'
  - the default UART parameter values
- Sub-module rr_picker: combinational round-robin selector. Inputs are a request vector and rr_ptr; outputs are a found flag and an index. It is reused by later arbiters.

Test Plan:
1. Requester 0 sends frame "S:2345\n" (7 bytes, last on 0x0A), with a uart_tx model whose busy rises 1 cycle after start and lasts 20 cycles -> exactly 7 tx_start pulses with tx_data 53,3A,32,33,34,35,0A; one frame_done; grant_id=0; no errors.
2. Both requesters go valid in the same cycle after reset, each with a 2-byte frame -> requester 0's frame is served first, then requester 1's; ready bits are never high together; rr_ptr ends at 0.
3. Requester 1 raises valid during requester 0's third byte -> requester 0 completes all bytes before any req_ready[1]; then requester 1 is granted.
4. tx_busy is tied low -> after each tx_start, err_timeout sets after exactly 16 wait cycles; the frame still completes with frame_done.
5. Requester 0 streams 20 bytes with no last -> the 16th byte ends the frame, frame_done pulses, err_trunc=1; byte 17 starts a new grant.
6. rst_n is pulled low during WAIT_LO of byte 2 -> on the next edge all outputs are 0 and state is IDLE; after release, a fresh 1-byte frame from requester 1 is granted normally.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared arbiter state encoding, formatter ASCII constants and UART defaults.
package uart_pkg;
    typedef enum logic [2:0] {IDLE, FETCH, START, WAIT_HI, WAIT_LO, DONE} arb_state_t;

    localparam logic [7:0] ASCII_S     = 8'h53;
    localparam logic [7:0] ASCII_L     = 8'h4C;
    localparam logic [7:0] ASCII_COLON = 8'h3A;
    localparam logic [7:0] ASCII_ZERO  = 8'h30;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    localparam int UART_NUM_REQ      = 2;
    localparam int UART_MAX_FRAME    = 16;
    localparam int UART_BUSY_TIMEOUT = 16;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin selector, first set request at or above ptr with wrap.
module rr_picker #(
    parameter int N = 2,
    localparam int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);
    logic [W-1:0] j;

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        found = 1'b0;
        idx = '0;
        j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = W'((int'(ptr) + k) % N);
            if (req[j]) begin
                found = 1'b1;
                idx = j;
            end
        end
    end
endmodule

// File: rtl/uart_tx_frame_arbiter.sv
// uart_tx_frame_arbiter: frame-atomic round-robin sharing of one uart_tx among NUM_REQ sources,
// with a watchdog on the tx_busy rise after each start pulse.
module uart_tx_frame_arbiter
    import uart_pkg::*;
#(
    parameter int NUM_REQ      = UART_NUM_REQ,
    parameter int MAX_FRAME    = UART_MAX_FRAME,
    parameter int BUSY_TIMEOUT = UART_BUSY_TIMEOUT,
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                 clk_100Mhz,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic [IW-1:0]        grant_id,
    output logic                 frame_active,
    output logic                 frame_done,
    output logic                 err_timeout,
    output logic                 err_trunc
);
    localparam int CW = $clog2(MAX_FRAME + 1);
    localparam int WW = $clog2(BUSY_TIMEOUT + 1);

    arb_state_t    state;
    logic [IW-1:0] rr_ptr;
    logic [CW-1:0] byte_cnt;
    logic [WW-1:0] wd_cnt;
    logic          last_q;
    logic          trunc_q;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          hs;
    logic          at_cap;
    logic          wd_expired;
    logic          byte_end;
    logic [IW-1:0] next_ptr;

    rr_picker #(.N(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    assign hs         = (state == FETCH) && req_valid[grant_id] && !tx_busy;
    assign at_cap     = byte_cnt == CW'(MAX_FRAME - 1);
    assign wd_expired = wd_cnt == WW'(BUSY_TIMEOUT - 1);
    // A watchdog expiry counts as the byte having gone out, so it shares the WAIT_LO exit.
    assign byte_end   = !tx_busy && ((state == WAIT_LO) || (state == WAIT_HI && wd_expired));
    assign next_ptr   = (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + IW'(1);

    always_comb begin
        req_ready = '0;
        req_ready[grant_id] = hs;
    end

    always_ff @(posedge clk_100Mhz) begin
        if (!rst_n) begin
            state        <= IDLE;
            rr_ptr       <= '0;
            byte_cnt     <= '0;
            wd_cnt       <= '0;
            last_q       <= 1'b0;
            trunc_q      <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            frame_active <= 1'b0;
            frame_done   <= 1'b0;
            err_timeout  <= 1'b0;
            err_trunc    <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frame_done <= 1'b0;
            if (byte_end) begin
                state <= last_q ? DONE : FETCH;
                if (last_q) begin
                    frame_done   <= 1'b1;
                    frame_active <= 1'b0;
                    err_trunc    <= err_trunc | trunc_q;
                    rr_ptr       <= next_ptr;
                end
            end
            case (state)
                IDLE: if (pick_found) begin
                    grant_id     <= pick_idx;
                    frame_active <= 1'b1;
                    byte_cnt     <= '0;
                    state        <= FETCH;
                end
                FETCH: if (hs) begin
                    tx_data  <= req_data[{grant_id, 3'b000} +: 8];
                    last_q   <= req_last[grant_id] || at_cap;
                    trunc_q  <= at_cap && !req_last[grant_id];
                    byte_cnt <= byte_cnt + CW'(1);
                    tx_start <= 1'b1;
                    state    <= START;
                end
                START: begin
                    wd_cnt <= '0;
                    state  <= WAIT_HI;
                end
                WAIT_HI: if (tx_busy) begin
                    state <= WAIT_LO;
                end else begin
                    wd_cnt <= wd_cnt + WW'(1);
                    err_timeout <= err_timeout | wd_expired;
                end
                WAIT_LO: ;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
